// File: rtl/nios_system2_debug_pkg.sv
// Shared definitions for the Nios II debug virtual-JTAG initiator:
// scan FSM states, virtual IR codes and default scan geometry.
package nios_system2_debug_pkg;

   localparam int DEF_DR_WIDTH = 38;
   localparam int DEF_IR_WIDTH = 2;

   localparam logic [1:0] IR_OCIMEM    = 2'b00;
   localparam logic [1:0] IR_TRACEMEM  = 2'b01;
   localparam logic [1:0] IR_BREAK     = 2'b10;
   localparam logic [1:0] IR_TRACECTRL = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_UIR,
      ST_CDR,
      ST_SDR,
      ST_UDR,
      ST_RSP
   } jtag_state_e;

endpackage

// File: rtl/nios_system2_debug_tck_gen.sv
// Scan-clock divider. While enabled, produces a tck period of 2*TCK_HALF clk
// cycles: low for the first TCK_HALF cycles, high for the second TCK_HALF.
// Ports:
//   i_clk, i_reset_n  : clock, synchronous active-low reset
//   i_en              : run the divider; when low it is parked at count 0, tck 0
//   o_tck             : registered scan clock
//   o_step_start      : the coming clk edge starts a new step (tck falling point)
//   o_tck_rise        : the coming clk edge drives tck 0->1
module nios_system2_debug_tck_gen #(
   parameter int TCK_HALF = 2
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic i_en,
   output logic o_tck,
   output logic o_step_start,
   output logic o_tck_rise
);

   localparam int              DIV_W = (2 * TCK_HALF > 1) ? $clog2(2 * TCK_HALF) : 1;
   localparam logic [DIV_W-1:0] LAST  = DIV_W'(2 * TCK_HALF - 1);
   localparam logic [DIV_W-1:0] RISE  = DIV_W'(TCK_HALF - 1);
   localparam logic [DIV_W-1:0] HIGH  = DIV_W'(TCK_HALF);

   logic [DIV_W-1:0] r_div;
   logic             r_tck;
   logic [DIV_W-1:0] w_div_nxt;

   assign w_div_nxt = (r_div == LAST) ? '0 : r_div + DIV_W'(1);

   always_ff @(posedge i_clk) begin
      if (!i_reset_n || !i_en) begin
         r_div <= '0;
         r_tck <= 1'b0;
      end else begin
         r_div <= w_div_nxt;
         r_tck <= (w_div_nxt >= HIGH);
      end
   end

   assign o_tck        = r_tck;
   assign o_step_start = i_en && (r_div == LAST);
   assign o_tck_rise   = i_en && (r_div == RISE);

endmodule

// File: rtl/nios_system2_debug_jtag_initiator.sv
// Virtual-JTAG scan initiator for the Nios II debug slave. Each accepted
// command runs update-IR, then (unless IR-only) capture-DR, DR_WIDTH shift
// steps and update-DR, and returns the shifted-out DR word as a response.
// Ports:
//   i_clk, i_reset_n              : clock, synchronous active-low reset
//   i_cmd_valid/o_cmd_ready       : command handshake
//   i_cmd_ir, i_cmd_ir_only,
//   i_cmd_data                    : IR value, IR-only flag, DR word (LSB first)
//   o_rsp_valid/i_rsp_ready       : response handshake
//   o_rsp_data, o_rsp_ir_out      : captured DR word, IR status from UDR step
//   o_vji_tck, o_vji_tdi, i_vji_tdo, o_vji_ir_in, i_vji_ir_out,
//   o_vji_uir/cdr/sdr/udr/rti     : virtual-JTAG pins toward the debug slave
module nios_system2_debug_jtag_initiator
   import nios_system2_debug_pkg::*;
#(
   parameter int DR_WIDTH = DEF_DR_WIDTH,
   parameter int IR_WIDTH = DEF_IR_WIDTH,
   parameter int TCK_HALF = 2
) (
   input  logic                i_clk,
   input  logic                i_reset_n,
   input  logic                i_cmd_valid,
   output logic                o_cmd_ready,
   input  logic [IR_WIDTH-1:0] i_cmd_ir,
   input  logic                i_cmd_ir_only,
   input  logic [DR_WIDTH-1:0] i_cmd_data,
   output logic                o_rsp_valid,
   input  logic                i_rsp_ready,
   output logic [DR_WIDTH-1:0] o_rsp_data,
   output logic [IR_WIDTH-1:0] o_rsp_ir_out,
   output logic                o_vji_tck,
   output logic                o_vji_tdi,
   input  logic                i_vji_tdo,
   output logic [IR_WIDTH-1:0] o_vji_ir_in,
   input  logic [IR_WIDTH-1:0] i_vji_ir_out,
   output logic                o_vji_uir,
   output logic                o_vji_cdr,
   output logic                o_vji_sdr,
   output logic                o_vji_udr,
   output logic                o_vji_rti
);

   localparam int CNT_W = (DR_WIDTH > 1) ? $clog2(DR_WIDTH) : 1;

   jtag_state_e         r_state, w_state_nxt;
   logic                r_ir_only;
   logic [IR_WIDTH-1:0] r_ir_q;
   logic [DR_WIDTH-1:0] r_shift;
   logic [CNT_W-1:0]    r_bit_cnt;
   logic                r_tdi;
   logic [IR_WIDTH-1:0] r_rsp_ir;

   logic w_en, w_step_start, w_tck_rise, w_tck;

   // The divider only runs while a scan is in flight, so every scan starts
   // with tck low at the beginning of the UIR step.
   assign w_en = (r_state != ST_IDLE) && (r_state != ST_RSP);

   nios_system2_debug_tck_gen #(
      .TCK_HALF (TCK_HALF)
   ) u_tck_gen (
      .i_clk        (i_clk),
      .i_reset_n    (i_reset_n),
      .i_en         (w_en),
      .o_tck        (w_tck),
      .o_step_start (w_step_start),
      .o_tck_rise   (w_tck_rise)
   );

   always_ff @(posedge i_clk) begin
      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (!i_reset_n) begin
         w_state_nxt = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE: if (i_cmd_valid)  w_state_nxt = ST_UIR;
            ST_UIR:  if (w_step_start) w_state_nxt = r_ir_only ? ST_RSP : ST_CDR;
            ST_CDR:  if (w_step_start) w_state_nxt = ST_SDR;
            ST_SDR:  if (w_step_start && (r_bit_cnt == '0)) w_state_nxt = ST_UDR;
            ST_UDR:  if (w_step_start) w_state_nxt = ST_RSP;
            ST_RSP:  if (i_rsp_ready)  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_ir_only <= 1'b0;
         r_ir_q    <= '0;
         r_shift   <= '0;
         r_bit_cnt <= '0;
         r_tdi     <= 1'b0;
         r_rsp_ir  <= '0;
      end else begin
         if (r_state == ST_IDLE && i_cmd_valid) begin
            r_ir_q    <= i_cmd_ir;
            r_shift   <= i_cmd_data;
            r_ir_only <= i_cmd_ir_only;
         end
         if (r_state == ST_CDR && w_step_start)
            r_bit_cnt <= CNT_W'(DR_WIDTH - 1);
         else if (r_state == ST_SDR && w_step_start && r_bit_cnt != '0)
            r_bit_cnt <= r_bit_cnt - CNT_W'(1);
         if (r_state == ST_SDR && w_tck_rise)
            r_shift <= {i_vji_tdo, r_shift[DR_WIDTH-1:1]};
         // tdi is registered at step boundaries so it stays put across the
         // mid-step shift; by then shift_q[0] already holds the next bit.
         if (w_step_start)
            r_tdi <= (w_state_nxt == ST_SDR) ? r_shift[0] : 1'b0;
         if (r_state == ST_UDR && w_tck_rise)
            r_rsp_ir <= i_vji_ir_out;
      end
   end

   assign o_cmd_ready  = (r_state == ST_IDLE);
   assign o_rsp_valid  = (r_state == ST_RSP);
   assign o_rsp_data   = (r_state == ST_RSP && !r_ir_only) ? r_shift : '0;
   assign o_rsp_ir_out = r_rsp_ir;
   assign o_vji_tck    = w_tck;
   assign o_vji_tdi    = r_tdi;
   assign o_vji_ir_in  = r_ir_q;
   assign o_vji_uir    = (r_state == ST_UIR);
   assign o_vji_cdr    = (r_state == ST_CDR);
   assign o_vji_sdr    = (r_state == ST_SDR);
   assign o_vji_udr    = (r_state == ST_UDR);
   assign o_vji_rti    = (r_state == ST_IDLE) || (r_state == ST_RSP);

endmodule

// File: doc/nios_system2_debug_jtag_initiator.md
# nios_system2_debug_jtag_initiator

Initiator side of the Nios II debug-slave virtual-JTAG interface. Turns a command (2-bit IR plus 38-bit DR word) into a complete virtual-JTAG scan: update-IR, capture-DR, DR_WIDTH shift steps, update-DR. The shifted-out DR word is returned on a response channel. It sits in place of the `sld_virtual_jtag_basic` hub in simulation and self-test builds, driving the `vji_*` pins of the CPU debug slave from `clk`.

## Interface
- `DR_WIDTH`, 38: scan length in bits; equals the debug slave `sr` width.
- `IR_WIDTH`, 2: virtual IR width.
- `TCK_HALF`, 2: `clk` cycles per `vji_tck` half-period; must be ≥1.
- `clk`  in  1: single system clock.
- `reset_n`  in  1: reset, synchronous and active-low.
- `cmd_valid`  in  1: command offered.
- `cmd_ready`  out  1: command accepted when `cmd_valid` && `cmd_ready`.
- `cmd_ir`  in  IR_WIDTH: virtual IR value to load.
- `cmd_ir_only`  in  1: 1 = run the IR step only, with no DR scan.
- `cmd_data`  in  DR_WIDTH: DR word to shift in, LSB first.
- `rsp_valid`  out  1: response available.
- `rsp_ready`  in  1: response consumed when `rsp_valid` && `rsp_ready`.
- `rsp_data`  out  DR_WIDTH: DR word captured from `vji_tdo`.
- `rsp_ir_out`  out  IR_WIDTH: `vji_ir_out` as sampled during the UDR step.
- `vji_tck`, `vji_tdi`  out  1: scan clock and scan data toward the slave.
- `vji_tdo`  in  1: scan data from the slave.
- `vji_ir_in`  out  IR_WIDTH: IR value driven to the slave.
- `vji_ir_out`  in  IR_WIDTH: IR status returned by the slave.
- `vji_uir`, `vji_cdr`, `vji_sdr`, `vji_udr`, `vji_rti`  out  1 each: virtual state flags.

## Operation
- A *step* is one `vji_tck` period of 2×TCK_HALF clk cycles.
  - `vji_tck` is low for the first TCK_HALF cycles of a step and high for the second TCK_HALF cycles.
  - All `vji_*` outputs change only on the clk edge that starts a step, which is a `vji_tck` falling point. They are held for the whole step.
- FSM states: IDLE, UIR, CDR, SDR, UDR, RSP.
- **IDLE**
  - `cmd_ready`=1, `vji_rti`=1, `vji_tck`=0.
  - On accept: latch `cmd_ir`, `cmd_data` and `cmd_ir_only` into `ir_q` and `shift_q`, then go to UIR.
- **UIR** (1 step)
  - `vji_uir`=1 and `vji_ir_in`=`ir_q`.
  - Next state: RSP if `cmd_ir_only`, otherwise CDR.
- **CDR** (1 step)
  - `vji_cdr`=1.
- **SDR** (DR_WIDTH steps, counted by `bit_cnt` from DR_WIDTH−1 down to 0)
  - `vji_sdr`=1 and `vji_tdi`=`shift_q[0]`.
  - On the clk edge that drives `vji_tck` 0→1, sample `vji_tdo`, then update `shift_q` ← {`vji_tdo`, `shift_q[DR_WIDTH−1:1]`}.
- **UDR** (1 step)
  - `vji_udr`=1.
  - `rsp_ir_out` ← `vji_ir_out`, sampled on the rising point of `vji_tck`.
- **RSP**
  - `rsp_valid`=1, `rsp_data`=`shift_q` (0 if the command was IR-only).
  - Hold until `rsp_ready`, then return to IDLE.
- `vji_ir_in` holds `ir_q` from UIR until the next command is accepted.
- `vji_tdi` is 0 outside SDR.
- Exactly one of `uir`/`cdr`/`sdr`/`udr`/`rti` is 1 in any cycle. RSP drives all five to 0 except `rti`=1.
- `cmd_valid` is ignored while busy. A new command is accepted in the cycle after the response handshake, never in the same cycle.

## Timing
- Reset values:
  - `vji_tck`, `vji_tdi`, `vji_uir`, `vji_cdr`, `vji_sdr`, `vji_udr`, `rsp_valid`, `rsp_data`, `rsp_ir_out`, `vji_ir_in` = 0.
  - `vji_rti`=1, `cmd_ready`=1, FSM=IDLE, divider=0.
- Reset asserted mid-scan: the scan is aborted at the next clk edge and no response is produced. `vji_tck` returns to 0 even if it was high.
- Latency from accept to `rsp_valid`=1:
  - full scan: (DR_WIDTH+3)×2×TCK_HALF + 1 clk, which is 165 for the defaults;
  - IR-only: 2×TCK_HALF + 1 clk.
- `rsp_valid` asserts on the clk after the last UDR cycle (or the last UIR cycle for IR-only).
- Throughput: at most one command per latency + 2 clk.
- `rsp_ready` held at 1 gives a back-to-back gap of 1 IDLE cycle.

## Structure
- Shared package `nios_system2_debug_pkg` holds:
  - the FSM state enum;
  - IR codes `IR_OCIMEM`=2'b00, `IR_TRACEMEM`=2'b01, `IR_BREAK`=2'b10, `IR_TRACECTRL`=2'b11;
  - default `DR_WIDTH`/`IR_WIDTH` constants.
- Sub-module `nios_system2_debug_tck_gen` is the TCK_HALF divider.
  - Outputs the registered `tck` plus the one-cycle strobes `step_start` (fall point) and `tck_rise`.
  - It is enabled only when the FSM is not in IDLE or RSP.
  - It is cleared by `reset_n`.

## Test plan
- After reset, hold `cmd_valid`=0 → `vji_rti`=1, `cmd_ready`=1, all other outputs 0 for 20 cycles.
- Scan against a 38-bit shift-register slave model preloaded with 38'h2A_5555_AAAA, with `cmd_ir`=2'b10 and `cmd_data`=38'h15_0F0F_F0F0:
  - `rsp_data`=38'h2A_5555_AAAA;
  - the model ends holding 38'h15_0F0F_F0F0;
  - `rsp_valid` rises exactly 165 clk after accept;
  - exactly 38 `vji_tck` rising edges occur with `vji_sdr`=1.
- IR-only command with `cmd_ir`=2'b11 → one `vji_uir` step with `vji_ir_in`=2'b11, no `cdr`/`sdr`/`udr`, `rsp_valid` 5 clk after accept, `rsp_data`=0.
- Hold `rsp_ready`=0 for 50 cycles, with `cmd_valid` held high carrying a second command → `rsp_valid` and `rsp_data` stable, `cmd_ready`=0, no `vji_tck` activity; the second command is accepted 1 cycle after the handshake.
- Drop `reset_n` for 1 cycle at SDR bit 17 while `vji_tck`=1 → next cycle all outputs equal their reset values, no `rsp_valid`; a following command completes normally.
- TCK_HALF=1 with `DR_WIDTH`=38, using the same data as the second scenario → same `rsp_data`, latency 83 clk, and `vji_tck` toggles every clk during the scan.
